// File: rtl/mux_share_sched.sv
// -----------------------------------------------------------------------------
// mux_share_sched
//
// Schedules a single shared 16:1 bit-select mux between NREQ single-bit read
// requesters and a full-word scan engine. The mux sits outside this block; it
// receives mux_sel and returns mux_out MUX_LATENCY edges after a select change.
// Each issued select is followed through the mux pipeline by a token. When a
// token retires, the returned bit becomes either a tagged response or one bit
// of the scan word.
//
// Optional feature (macro MUX_SHARE_SCHED_STARVE_EN):
//   Each requester gets a 4-bit wait counter. A requester whose counter has
//   reached 15 is granted ahead of round-robin order and ahead of a pending
//   scan_start. A scan_start deferred this way is remembered until it is taken.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, req_idx    per-requester request and 4-bit bit index
//   gnt             one-hot grant (combinational, valid in the accept cycle)
//   mux_sel         registered select to the shared mux
//   mux_out         bit returned by the shared mux
//   rsp_valid/id/bit  response pulse, owner ID and data bit
//   scan_start      pulse that requests a full 16-bit scan
//   scan_busy       high from scan accept until scan_done
//   scan_word       assembled scan result
//   scan_done       one-cycle pulse, scan_word complete
// -----------------------------------------------------------------------------
module mux_share_sched #(
  parameter int NREQ        = 4,
  parameter int ID_W        = 2,
  parameter int MUX_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*4-1:0] req_idx,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        mux_sel,
  input  logic              mux_out,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_bit,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic [15:0]       scan_word,
  output logic              scan_done
);

  localparam int DEPTH = MUX_LATENCY + 1;

  typedef enum logic [1:0] {ARB = 2'd0, SCAN_ISSUE = 2'd1, SCAN_DRAIN = 2'd2} state_e;

  // One entry per select still travelling through the external mux.
  typedef struct packed {
    logic            valid;
    logic            scan;
    logic [ID_W-1:0] id;
    logic [3:0]      idx;
  } token_t;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      mux_sel_q, mux_sel_d;
  token_t          pipe_q [DEPTH];
  token_t          pipe_d [DEPTH];
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_bit_q, rsp_bit_d;
  logic            scan_busy_q, scan_busy_d;
  logic [15:0]     scan_word_q, scan_word_d;
  logic            scan_done_q, scan_done_d;

  logic            rr_found_s;
  logic [ID_W-1:0] rr_pick_s;
  logic            grant_any_s;
  logic [ID_W-1:0] grant_id_s;
  logic            scan_accept_s;
  logic            scan_req_s;
  logic [NREQ-1:0] gnt_s;
  token_t          new_tok_s;
  token_t          retire_s;

`ifdef MUX_SHARE_SCHED_STARVE_EN
  logic [3:0]      wait_q [NREQ];
  logic [3:0]      wait_d [NREQ];
  logic            scan_pend_q, scan_pend_d;
  logic            starve_found_s;
  logic [ID_W-1:0] starve_pick_s;

  assign scan_req_s = scan_start | scan_pend_q;

  // Starvation detect (lowest index first) and wait counter update.
  always_comb begin
    starve_found_s = 1'b0;
    starve_pick_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!starve_found_s && req[i] && (wait_q[i] == 4'd15)) begin
        starve_found_s = 1'b1;
        starve_pick_s  = ID_W'(i);
      end else begin
        starve_found_s = starve_found_s;
      end
      if (gnt_s[i]) begin
        wait_d[i] = 4'd0;
      end else if (req[i] && (wait_q[i] != 4'd15)) begin
        wait_d[i] = wait_q[i] + 4'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
    // A scan_start pushed back by a starvation grant stays pending.
    scan_pend_d = (state_q == ARB) ? (scan_req_s & ~scan_accept_s) : 1'b0;
  end
`else
  assign scan_req_s = scan_start;
`endif

  // Round-robin search starting at rr_ptr and wrapping at NREQ.
  always_comb begin : rr_search
    int sum;
    logic [ID_W-1:0] pos;
    sum        = 0;
    pos        = '0;
    rr_found_s = 1'b0;
    rr_pick_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      sum = (sum >= NREQ) ? (sum - NREQ) : sum;
      pos = ID_W'(sum);
      if (!rr_found_s && req[pos]) begin
        rr_found_s = 1'b1;
        rr_pick_s  = pos;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant decision for this cycle; a scan request outranks plain requests.
  always_comb begin
    grant_any_s   = 1'b0;
    grant_id_s    = '0;
    scan_accept_s = 1'b0;
    if (!rst && (state_q == ARB)) begin
`ifdef MUX_SHARE_SCHED_STARVE_EN
      if (starve_found_s) begin
        grant_any_s = 1'b1;
        grant_id_s  = starve_pick_s;
      end else if (scan_req_s) begin
        scan_accept_s = 1'b1;
      end else if (rr_found_s) begin
        grant_any_s = 1'b1;
        grant_id_s  = rr_pick_s;
      end else begin
        grant_any_s = 1'b0;
      end
`else
      if (scan_req_s) begin
        scan_accept_s = 1'b1;
      end else if (rr_found_s) begin
        grant_any_s = 1'b1;
        grant_id_s  = rr_pick_s;
      end else begin
        grant_any_s = 1'b0;
      end
`endif
    end else begin
      grant_any_s = 1'b0;
    end
    gnt_s = '0;
    if (grant_any_s) begin
      gnt_s[grant_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign retire_s = pipe_q[DEPTH-1];

  // FSM next state, select issue, token pipe shift and retire handling.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    mux_sel_d   = mux_sel_q;
    scan_busy_d = scan_busy_q;
    scan_word_d = scan_word_q;
    scan_done_d = 1'b0;
    new_tok_s   = '0;

    case (state_q)
      ARB: begin
        if (scan_accept_s) begin
          state_d     = SCAN_ISSUE;
          scan_busy_d = 1'b1;
          cnt_d       = 4'd0;
        end else if (grant_any_s) begin
          mux_sel_d       = req_idx[{grant_id_s, 2'b00} +: 4];
          rr_ptr_d        = (grant_id_s == ID_W'(NREQ - 1)) ? '0 : grant_id_s + ID_W'(1);
          new_tok_s.valid = 1'b1;
          new_tok_s.scan  = 1'b0;
          new_tok_s.id    = grant_id_s;
          new_tok_s.idx   = req_idx[{grant_id_s, 2'b00} +: 4];
        end else begin
          mux_sel_d = mux_sel_q;
        end
      end
      SCAN_ISSUE: begin
        mux_sel_d       = cnt_q;
        new_tok_s.valid = 1'b1;
        new_tok_s.scan  = 1'b1;
        new_tok_s.idx   = cnt_q;
        cnt_d           = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = SCAN_DRAIN;
        end else begin
          state_d = SCAN_ISSUE;
        end
      end
      SCAN_DRAIN: begin
        // Bit 15 is always the last scan token out of the pipe.
        if (retire_s.valid && retire_s.scan && (retire_s.idx == 4'd15)) begin
          state_d     = ARB;
          scan_busy_d = 1'b0;
          scan_done_d = 1'b1;
        end else begin
          state_d = SCAN_DRAIN;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase

    pipe_d[0] = new_tok_s;
    for (int k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end

    rsp_valid_d = retire_s.valid & ~retire_s.scan;
    rsp_id_d    = rsp_valid_d ? retire_s.id : rsp_id_q;
    rsp_bit_d   = rsp_valid_d ? mux_out : rsp_bit_q;
    if (retire_s.valid && retire_s.scan) begin
      scan_word_d[retire_s.idx] = mux_out;
    end else begin
      scan_word_d = scan_word_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      cnt_q       <= 4'd0;
      mux_sel_q   <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_bit_q   <= 1'b0;
      scan_busy_q <= 1'b0;
      scan_word_q <= 16'd0;
      scan_done_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
`ifdef MUX_SHARE_SCHED_STARVE_EN
      scan_pend_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= 4'd0;
      end
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mux_sel_q   <= mux_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_bit_q   <= rsp_bit_d;
      scan_busy_q <= scan_busy_d;
      scan_word_q <= scan_word_d;
      scan_done_q <= scan_done_d;
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
`ifdef MUX_SHARE_SCHED_STARVE_EN
      scan_pend_q <= scan_pend_d;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
`endif
    end
  end

  assign gnt       = gnt_s;
  assign mux_sel   = mux_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_bit   = rsp_bit_q;
  assign scan_busy = scan_busy_q;
  assign scan_word = scan_word_q;
  assign scan_done = scan_done_q;

endmodule
